// File: rtl/param_query_responder.sv
`default_nettype none
// ============================================================================
// Module   : param_query_responder
// Brief    : Answers "parameter idx, bits [left:right]" queries against a
//            fixed table of parameter values. The selected field is returned
//            right-aligned and zero-extended. Valid/ready on both sides, one
//            query in flight; the part select is done by a serial shifter.
// Revision : 1.0 - initial release
// ============================================================================
module param_query_responder #(
    parameter int NUM_PARAMS = 4,
    parameter int PARAM_W    = 32,
    parameter logic [NUM_PARAMS*PARAM_W-1:0] PARAM_VALUES =
        {32'h0000_00AA, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_0001},
    // Derived widths; not meant to be overridden.
    parameter int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1,
    parameter int RNG_W = $clog2(PARAM_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IDX_W-1:0]   req_idx,
    input  logic [RNG_W-1:0]   req_left,
    input  logic [RNG_W-1:0]   req_right,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [PARAM_W-1:0] rsp_data,
    output logic [RNG_W:0]     rsp_width,
    output logic               rsp_err
);

    // Table is padded to a power of two so any req_idx value indexes safely.
    localparam int TBL_N = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PARAM_W-1:0]   r_work;
    logic [RNG_W-1:0]     r_cnt;
    logic [RNG_W-1:0]     r_left;
    logic [RNG_W-1:0]     r_right;
    logic [PARAM_W-1:0]   w_table [TBL_N];
    logic                 w_accept;
    logic                 w_req_err;
    logic [RNG_W:0]       w_width;
    logic [PARAM_W:0]     w_mask_full;
    logic                 w_unused_msb;

    // Unpack the flat parameter vector; unused slots read as zero.
    for (genvar gi = 0; gi < TBL_N; gi++) begin : g_table
        if (gi < NUM_PARAMS) begin : g_used
            assign w_table[gi] = PARAM_VALUES[gi*PARAM_W +: PARAM_W];
        end else begin : g_unused
            assign w_table[gi] = '0;
        end
    end

    assign w_accept  = req_valid && req_ready;
    assign w_req_err = (int'(req_idx) >= NUM_PARAMS) || (req_left < req_right);

    // Field width and mask use one extra bit so a full-width select gives all ones.
    assign w_width      = ({1'b0, r_left} - {1'b0, r_right}) + {{RNG_W{1'b0}}, 1'b1};
    assign w_mask_full  = ({{PARAM_W{1'b0}}, 1'b1} << w_width) - {{PARAM_W{1'b0}}, 1'b1};
    assign w_unused_msb = w_mask_full[PARAM_W];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = w_req_err ? S_RESP : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Query capture, serial right shift and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_left    <= '0;
            r_right   <= '0;
            rsp_data  <= '0;
            rsp_width <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_left  <= req_left;
                        r_right <= req_right;
                        if (w_req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_width <= '0;
                        end else begin
                            r_work <= w_table[req_idx];
                            r_cnt  <= req_right;
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_work <= r_work >> 1;
                        r_cnt  <= r_cnt - 1'b1;
                    end else begin
                        rsp_data  <= r_work & w_mask_full[PARAM_W-1:0];
                        rsp_width <= w_width;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_query_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_query_responder
// Brief    : Self-checking bench for param_query_responder. Directed and
//            random queries are compared against a table-lookup reference
//            model; a second instance covers a reduced-size table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_query_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_idx = '0;
    logic [4:0]  req_left = '0;
    logic [4:0]  req_right = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_width;
    logic        rsp_err;

    // Reduced three-entry instance
    logic        b_req_valid = 1'b0;
    logic        b_req_ready;
    logic [1:0]  b_req_idx = '0;
    logic [4:0]  b_req_left = '0;
    logic [4:0]  b_req_right = '0;
    logic        b_rsp_valid;
    logic        b_rsp_ready = 1'b0;
    logic [31:0] b_rsp_data;
    logic [5:0]  b_rsp_width;
    logic        b_rsp_err;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_table [4] = '{32'h0000_0001, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_00AA};

    always #5 clk = ~clk;

    param_query_responder dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_left(req_left), .req_right(req_right),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_width(rsp_width), .rsp_err(rsp_err)
    );

    param_query_responder #(
        .NUM_PARAMS(3),
        .PARAM_VALUES({32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_0001})
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_idx(b_req_idx),
        .req_left(b_req_left), .req_right(b_req_right),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_width(b_rsp_width), .rsp_err(b_rsp_err)
    );

    // Reference: direct table lookup, shift and mask in wide arithmetic.
    function automatic void model(input int idx, input int l, input int r,
                                  output logic [31:0] d, output logic [5:0] w,
                                  output logic e, output int lat);
        longint unsigned v;
        if (idx >= 4 || l < r) begin
            d = '0; w = '0; e = 1'b1; lat = 1;
        end else begin
            v   = 64'(ref_table[idx]);
            d   = 32'((v >> r) & ((64'd1 << (l - r + 1)) - 64'd1));
            w   = 6'(l - r + 1);
            e   = 1'b0;
            lat = r + 2;
        end
    endfunction

    task automatic run_query(input int idx, input int l, input int r, input int stall, input string name);
        logic [31:0] ed; logic [5:0] ew; logic ee; int el; int k;
        model(idx, l, r, ed, ew, ee, el);
        @(negedge clk);
        req_idx = 2'(idx); req_left = 5'(l); req_right = 5'(r);
        req_valid = 1'b1; rsp_ready = 1'b0;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL %s req_ready got=%b want=1", name, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 100) begin
            @(negedge clk); k++;
        end
        vectors++;
        if (k != el) begin
            miscompares++; $display("FAIL %s latency got=%0d want=%0d", name, k, el);
        end
        vectors++;
        if ({rsp_data, rsp_width, rsp_err} !== {ed, ew, ee}) begin
            miscompares++;
            $display("FAIL %s rsp got data=%h width=%0d err=%b want data=%h width=%0d err=%b",
                     name, rsp_data, rsp_width, rsp_err, ed, ew, ee);
        end
        // Stalled response: stray requests must be ignored, outputs held.
        for (int s = 0; s < stall; s++) begin
            req_valid = 1'b1; req_idx = 2'($urandom_range(0, 3));
            req_left = 5'($urandom_range(0, 31)); req_right = 5'($urandom_range(0, 31));
            @(negedge clk);
            vectors++;
            if ({rsp_valid, req_ready, rsp_data, rsp_width, rsp_err} !== {1'b1, 1'b0, ed, ew, ee}) begin
                miscompares++;
                $display("FAIL %s stall%0d got valid=%b ready=%b data=%h width=%0d err=%b want valid=1 ready=0 data=%h width=%0d err=%b",
                         name, s, rsp_valid, req_ready, rsp_data, rsp_width, rsp_err, ed, ew, ee);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s after_handshake got valid=%b ready=%b want valid=0 ready=1", name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_data, rsp_width, rsp_err} !== {1'b1, 1'b0, 32'h0, 6'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset got ready=%b valid=%b data=%h width=%0d err=%b want 1 0 0 0 0",
                     req_ready, rsp_valid, rsp_data, rsp_width, rsp_err);
        end
        vectors++;
        if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut3 got ready=%b valid=%b want 1 0", b_req_ready, b_rsp_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_query(1, 15, 8, 0, "idx1_15_8");
        run_query(1, 7, 0, 0, "idx1_7_0");
        run_query(2, 31, 0, 0, "idx2_full");
        run_query(0, 0, 0, 0, "idx0_0_0");
        run_query(3, 31, 31, 0, "idx3_31_31");
        run_query(1, 3, 8, 0, "err_left_lt_right");
    endtask

    task automatic test_err_small_table();
        int k;
        @(negedge clk);
        b_req_idx = 2'd3; b_req_left = 5'd5; b_req_right = 5'd2; b_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        k = 1;
        while (b_rsp_valid !== 1'b1 && k < 100) begin
            @(negedge clk); k++;
        end
        vectors++;
        if (k != 1) begin
            miscompares++; $display("FAIL err_idx3 latency got=%0d want=1", k);
        end
        vectors++;
        if ({b_rsp_err, b_rsp_data, b_rsp_width} !== {1'b1, 32'h0, 6'h0}) begin
            miscompares++;
            $display("FAIL err_idx3 got err=%b data=%h width=%0d want err=1 data=0 width=0",
                     b_rsp_err, b_rsp_data, b_rsp_width);
        end
        b_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int k;
        @(negedge clk);
        // First query: idx2 [11:4] -> 0xEE, latency 6
        req_idx = 2'd2; req_left = 5'd11; req_right = 5'd4; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Second query held pending for the whole first transaction
        req_idx = 2'd1; req_left = 5'd7; req_right = 5'd0;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 100) begin
            @(negedge clk); k++;
        end
        vectors++;
        if (k != 6 || rsp_data !== 32'hEE) begin
            miscompares++; $display("FAIL bp_first got lat=%0d data=%h want lat=6 data=ee", k, rsp_data);
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            vectors++;
            if ({rsp_valid, req_ready, rsp_data, rsp_width, rsp_err} !== {1'b1, 1'b0, 32'hEE, 6'd8, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got valid=%b ready=%b data=%h width=%0d err=%b want 1 0 ee 8 0",
                         s, rsp_valid, req_ready, rsp_data, rsp_width, rsp_err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 100) begin
            @(negedge clk); k++;
        end
        vectors++;
        if (k != 2 || rsp_data !== 32'h34 || rsp_width !== 6'd8) begin
            miscompares++;
            $display("FAIL bp_second got lat=%0d data=%h width=%0d want lat=2 data=34 width=8", k, rsp_data, rsp_width);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        req_idx = 2'd2; req_left = 5'd31; req_right = 5'd20; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_data, rsp_width, rsp_err} !== {1'b1, 1'b0, 32'h0, 6'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset got ready=%b valid=%b data=%h width=%0d err=%b want 1 0 0 0 0",
                     req_ready, rsp_valid, rsp_data, rsp_width, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_reset_aborted got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
            end
        end
        run_query(1, 15, 8, 0, "after_reset_idx1_15_8");
    endtask

    task automatic test_random();
        int idx, l, r;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 3);
            r   = $urandom_range(0, 31);
            l   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(r, 31);
            run_query(idx, l, r, $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_err_small_table();
        test_backpressure();
        test_random();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
